fft_mag_peak: RTL and testbench

//  Downstream of the 64-point FFT. Consumes the serial, natural-order bin stream.
//  Per bin: emits magnitude-squared |X|^2 = re^2 + im^2.
//  Per frame: reports the strongest bin (index and magnitude) once the frame ends.

---
 rtl/fft_mag_peak.sv | 193 +++++++++++++++++++
 tb/tb_fft_mag_peak.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_mag_peak.sv
// fft_mag_peak
//   Sits behind the 64-point FFT and consumes its serial, natural-order bin
//   stream.
//   - For every accepted bin it emits the magnitude squared, re^2 + im^2, with
//     a fixed latency of two cycles.
//   - For every completed frame it reports the strongest bin one cycle after
//     that frame's last magnitude.
//   Ports:
//     clk, reset          rising-edge clock, asynchronous active-high reset
//     in_valid, in_sync   input bin qualifier; in_sync marks bin 0 of a frame
//     in_real, in_imag    signed Q1.14 bin value
//     mag_valid, mag      unsigned Q2.28 |X|^2 and its strobe
//     mag_bin             bin index travelling with mag
//     peak_valid          one-cycle pulse per completed frame
//     peak_bin, peak_mag  strongest bin of that frame (held until next pulse)
module fft_mag_peak #(
  parameter int N       = 64,
  parameter int W       = 16,
  parameter bit SKIP_DC = 1'b0,
  localparam int LOG2N  = $clog2(N)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic                in_sync,
  input  logic signed [W-1:0] in_real,
  input  logic signed [W-1:0] in_imag,
  output logic                mag_valid,
  output logic [2*W-1:0]      mag,
  output logic [LOG2N-1:0]    mag_bin,
  output logic                peak_valid,
  output logic [LOG2N-1:0]    peak_bin,
  output logic [2*W-1:0]      peak_mag
);

  localparam logic [LOG2N-1:0] LAST_BIN = LOG2N'(N - 1);

  typedef enum logic {IDLE, RUN} state_e;

  // ---------------------------------------------------------------- input FSM
  state_e           state_q, state_d;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic             accept;
  logic [LOG2N-1:0] bin_in;

  // A sync sample is always bin 0, so a sync mid-frame drops the partial frame
  // simply by restarting the count.
  assign accept = in_valid && (in_sync || state_q == RUN);
  assign bin_in = in_sync ? '0 : cnt_q;

  // NOTE: every signal written here gets its default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      if (bin_in == LAST_BIN) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        state_d = RUN;
        cnt_d   = bin_in + LOG2N'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ------------------------------------------------------------ S1: squares
  // Both squares are non-negative and at most 2^30, so they fit 2W unsigned.
  logic signed [2*W-1:0] sq_re, sq_im;
  logic [2*W-1:0]        sq_re_q, sq_im_q;
  logic                  v1_q;
  logic [LOG2N-1:0]      bin1_q;

  assign sq_re = in_real * in_real;
  assign sq_im = in_imag * in_imag;

  // NOTE: the datapath registers are reset too, because every output must
  // read 0 while reset is held, not just the strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q    <= 1'b0;
      bin1_q  <= '0;
      sq_re_q <= '0;
      sq_im_q <= '0;
    end else begin
      v1_q <= accept;
      if (accept) begin
        bin1_q  <= bin_in;
        sq_re_q <= sq_re;
        sq_im_q <= sq_im;
      end
    end
  end

  // --------------------------------------------------------------- S2: sum
  // The worst case, 2^30 + 2^30, reaches exactly 2^31 and still fits.
  logic             mag_valid_q;
  logic [2*W-1:0]   mag_q;
  logic [LOG2N-1:0] mag_bin_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mag_valid_q <= 1'b0;
      mag_q       <= '0;
      mag_bin_q   <= '0;
    end else begin
      mag_valid_q <= v1_q;
      if (v1_q) begin
        mag_q     <= sq_re_q + sq_im_q;
        mag_bin_q <= bin1_q;
      end
    end
  end

  // ------------------------------------------------------------ peak search
  logic             frame_start, frame_end, cand;
  logic [2*W-1:0]   run_max_q, run_max_d;
  logic [LOG2N-1:0] run_bin_q, run_bin_d;
  logic             have_q, have_d;
  logic             peak_valid_q;
  logic [LOG2N-1:0] peak_bin_q, peak_bin_d;
  logic [2*W-1:0]   peak_mag_q, peak_mag_d;

  assign frame_start = mag_valid_q && (mag_bin_q == '0);
  assign frame_end   = mag_valid_q && (mag_bin_q == LAST_BIN);
  assign cand        = mag_valid_q && !(SKIP_DC && (mag_bin_q == '0));

  // Steps apply in order: a new frame re-arms the tracker, the current
  // magnitude may then take it (strict '>' keeps the lowest index on ties),
  // and a closing frame publishes the result and re-arms again.
  always_comb begin
    run_max_d  = run_max_q;
    run_bin_d  = run_bin_q;
    have_d     = have_q;
    peak_bin_d = peak_bin_q;
    peak_mag_d = peak_mag_q;
    if (frame_start) begin
      run_max_d = '0;
      run_bin_d = '0;
      have_d    = 1'b0;
    end
    if (cand && (!have_d || mag_q > run_max_d)) begin
      run_max_d = mag_q;
      run_bin_d = mag_bin_q;
      have_d    = 1'b1;
    end
    if (frame_end) begin
      peak_bin_d = run_bin_d;
      peak_mag_d = run_max_d;
      run_max_d  = '0;
      run_bin_d  = '0;
      have_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_max_q    <= '0;
      run_bin_q    <= '0;
      have_q       <= 1'b0;
      peak_valid_q <= 1'b0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
    end else begin
      run_max_q    <= run_max_d;
      run_bin_q    <= run_bin_d;
      have_q       <= have_d;
      peak_valid_q <= frame_end;
      peak_bin_q   <= peak_bin_d;
      peak_mag_q   <= peak_mag_d;
    end
  end

  assign mag_valid  = mag_valid_q;
  assign mag        = mag_q;
  assign mag_bin    = mag_bin_q;
  assign peak_valid = peak_valid_q;
  assign peak_bin   = peak_bin_q;
  assign peak_mag   = peak_mag_q;

endmodule

// File: tb/tb_fft_mag_peak.sv
// tb_fft_mag_peak
//   Drives two fft_mag_peak instances from the same input stream: one with
//   SKIP_DC=0 and one with SKIP_DC=1.
//   A frame-level model predicts, per cycle, every magnitude and every peak,
//   and a single negedge process compares both instances against it.
//   Directed frames pin the model with hand-computed constants.
module tb_fft_mag_peak;
  localparam int N = 64;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_sync = 1'b0;
  logic [W-1:0] in_real = '0;
  logic [W-1:0] in_imag = '0;

  logic         mv0, pv0, mv1, pv1;
  logic [31:0]  m0, pm0, m1, pm1;
  logic [5:0]   mb0, pb0, mb1, pb1;

  fft_mag_peak #(.N(N), .W(W), .SKIP_DC(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sync(in_sync),
    .in_real(in_real), .in_imag(in_imag),
    .mag_valid(mv0), .mag(m0), .mag_bin(mb0),
    .peak_valid(pv0), .peak_bin(pb0), .peak_mag(pm0));

  fft_mag_peak #(.N(N), .W(W), .SKIP_DC(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sync(in_sync),
    .in_real(in_real), .in_imag(in_imag),
    .mag_valid(mv1), .mag(m1), .mag_bin(mb1),
    .peak_valid(pv1), .peak_bin(pb1), .peak_mag(pm1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  bit           in_frame = 1'b0;
  int           next_bin = 0;
  longint       fm [N];
  bit [31:0]    e_mag [int];
  int           e_bin [int];
  bit           pk_e  [int];
  int           pk_b0 [int];
  int           pk_b1 [int];
  bit [31:0]    pk_m0 [int];
  bit [31:0]    pk_m1 [int];
  int           last_drive_cyc = 0;

  function automatic longint sq_mag(input logic [W-1:0] re, input logic [W-1:0] im);
    longint r = longint'($signed(re));
    longint i = longint'($signed(im));
    return r * r + i * i;
  endfunction

  // Strongest bin of the completed frame; first occurrence wins ties.
  function automatic int peak_idx(input bit skip);
    int best  = -1;
    int start = skip ? 1 : 0;
    for (int i = start; i < N; i++)
      if (best < 0 || fm[i] > fm[best]) best = i;
    return best;
  endfunction

  task automatic model_accept(input bit s, input logic [W-1:0] re, input logic [W-1:0] im);
    int     bin = s ? 0 : next_bin;
    longint m   = sq_mag(re, im);
    e_mag[cyc + 2] = m[31:0];
    e_bin[cyc + 2] = bin;
    fm[bin] = m;
    last_drive_cyc = cyc;
    if (bin == N - 1) begin
      int b0 = peak_idx(1'b0);
      int b1 = peak_idx(1'b1);
      pk_e[cyc + 3]  = 1'b1;
      pk_b0[cyc + 3] = b0;
      pk_b1[cyc + 3] = b1;
      pk_m0[cyc + 3] = fm[b0][31:0];
      pk_m1[cyc + 3] = fm[b1][31:0];
      in_frame = 1'b0;
      next_bin = 0;
    end else begin
      in_frame = 1'b1;
      next_bin = bin + 1;
    end
  endtask

  // ---------------------------------------------------------------- compare
  bit [31:0] held_m0 = '0, held_m1 = '0;
  bit [31:0] seen_mag0 [N];
  int        last_pb0 = 0, last_pb1 = 0;
  bit [31:0] last_pm0 = '0, last_pm1 = '0;
  int        pk_cnt = 0, mv_cnt = 0, pk_cyc = 0;
  bit        exp_mv, exp_pv;

  always @(negedge clk) begin
    if (reset) begin
      check("rst_mag_valid0", mv0, 0);
      check("rst_mag0", m0, 0);
      check("rst_mag_bin0", mb0, 0);
      check("rst_peak_valid0", pv0, 0);
      check("rst_peak_bin0", pb0, 0);
      check("rst_peak_mag0", pm0, 0);
      check("rst_mag_valid1", mv1, 0);
      check("rst_peak_mag1", pm1, 0);
      held_m0 = '0;
      held_m1 = '0;
    end else begin
      exp_mv = e_mag.exists(cyc);
      exp_pv = pk_e.exists(cyc);
      check("mag_valid0", mv0, exp_mv);
      check("mag_valid1", mv1, exp_mv);
      if (exp_mv) begin
        check("mag0", m0, e_mag[cyc]);
        check("mag1", m1, e_mag[cyc]);
        check("mag_bin0", mb0, e_bin[cyc]);
        check("mag_bin1", mb1, e_bin[cyc]);
        e_mag.delete(cyc);
        e_bin.delete(cyc);
      end
      check("peak_valid0", pv0, exp_pv);
      check("peak_valid1", pv1, exp_pv);
      if (exp_pv) begin
        check("peak_bin0", pb0, pk_b0[cyc]);
        check("peak_bin1", pb1, pk_b1[cyc]);
        held_m0 = pk_m0[cyc];
        held_m1 = pk_m1[cyc];
        pk_e.delete(cyc);
      end
      check("peak_mag0", pm0, held_m0);
      check("peak_mag1", pm1, held_m1);
    end
    if (mv0) begin
      seen_mag0[mb0] = m0;
      mv_cnt++;
    end
    if (pv0) begin
      last_pb0 = pb0;
      last_pm0 = pm0;
      pk_cnt++;
      pk_cyc = cyc;
    end
    if (pv1) begin
      last_pb1 = pb1;
      last_pm1 = pm1;
    end
  end

  // ---------------------------------------------------------------- drivers
  logic [W-1:0] fr_re [N];
  logic [W-1:0] fr_im [N];

  function automatic logic [W-1:0] rnd();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic drive(input bit v, input bit s, input logic [W-1:0] re, input logic [W-1:0] im);
    @(posedge clk);
    #1;
    in_valid = v;
    in_sync  = s;
    in_real  = re;
    in_imag  = im;
    if (v && (s || in_frame)) model_accept(s, re, im);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sync  = 1'b0;
    e_mag.delete(); e_bin.delete(); pk_e.delete();
    pk_b0.delete(); pk_b1.delete(); pk_m0.delete(); pk_m1.delete();
    in_frame = 1'b0;
    next_bin = 0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic clear_frame();
    for (int i = 0; i < N; i++) begin
      fr_re[i] = '0;
      fr_im[i] = '0;
    end
  endtask

  task automatic rand_frame();
    for (int i = 0; i < N; i++) begin
      fr_re[i] = rnd();
      fr_im[i] = rnd();
    end
  endtask

  task automatic send_frame(input int gap_pct, input bit flush);
    for (int i = 0; i < N; i++) begin
      if (i > 0 && $urandom_range(0, 99) < gap_pct) begin
        int g = $urandom_range(1, 3);
        repeat (g) drive(1'b0, 1'b0, rnd(), rnd());
      end
      drive(1'b1, i == 0, fr_re[i], fr_im[i]);
    end
    if (flush) idle(6);
  endtask

  // ---------------------------------------------------------------- sequence
  int pk0, mv0_base;

  initial begin
    do_reset(3);
    idle(3);

    // Reset at bin 30 discards the frame; the next frame stands alone.
    pk0 = pk_cnt;
    for (int i = 0; i < 30; i++) drive(1'b1, i == 0, rnd(), rnd());
    do_reset(2);
    @(negedge clk);
    check("t1_rst_mag_valid", mv0, 0);
    check("t1_rst_peak_mag", pm0, 0);
    idle(5);
    check("t1_no_peak_after_reset", pk_cnt - pk0, 0);
    rand_frame();
    send_frame(20, 1'b1);
    check("t1_one_peak", pk_cnt - pk0, 1);

    // Single tone at bin 5.
    clear_frame();
    fr_re[5] = 16'h2000;
    fr_im[5] = 16'h2000;
    send_frame(0, 1'b1);
    check("t2_mag5", seen_mag0[5], 32'h0800_0000);
    check("t2_peak_bin", last_pb0, 5);
    check("t2_peak_mag", last_pm0, 32'h0800_0000);
    check("t2_peak_latency", pk_cyc - last_drive_cyc, 3);

    // Tie between bins 9 and 40.
    clear_frame();
    fr_re[9]  = 16'h4000;
    fr_re[40] = 16'h4000;
    send_frame(10, 1'b1);
    check("t3_mag40", seen_mag0[40], 32'h1000_0000);
    check("t3_peak_bin", last_pb0, 9);
    check("t3_peak_mag", last_pm0, 32'h1000_0000);

    // Full-scale DC versus a small tone, with and without DC exclusion.
    clear_frame();
    fr_re[0]  = 16'h8000;
    fr_im[0]  = 16'h8000;
    fr_re[17] = 16'h0100;
    send_frame(0, 1'b1);
    check("t4_mag0", seen_mag0[0], 32'h8000_0000);
    check("t4_peak_bin_dc", last_pb0, 0);
    check("t4_peak_mag_dc", last_pm0, 32'h8000_0000);
    check("t4_peak_bin_skip", last_pb1, 17);
    check("t4_peak_mag_skip", last_pm1, 32'h0001_0000);

    // Back-to-back frames with random gaps.
    pk0 = pk_cnt;
    mv0_base = mv_cnt;
    rand_frame();
    send_frame(30, 1'b0);
    rand_frame();
    send_frame(30, 1'b1);
    check("t5_two_peaks", pk_cnt - pk0, 2);
    check("t5_all_mags", mv_cnt - mv0_base, 2 * N);

    // Sync at bin 20 drops frame A; then stray valid while idle is ignored.
    pk0 = pk_cnt;
    mv0_base = mv_cnt;
    for (int i = 0; i < 20; i++) drive(1'b1, i == 0, rnd(), rnd());
    rand_frame();
    send_frame(0, 1'b1);
    check("t6_one_peak", pk_cnt - pk0, 1);
    check("t6_mag_count", mv_cnt - mv0_base, 20 + N);
    mv0_base = mv_cnt;
    repeat (6) drive(1'b1, 1'b0, rnd(), rnd());
    idle(4);
    check("t6_idle_ignored", mv_cnt - mv0_base, 0);

    // Random stress: gaps, occasional mid-frame syncs, frames starting on
    // the cycle after bin 63.
    for (int k = 0; k < 3000; k++) begin
      bit v = ($urandom_range(0, 3) != 0);
      bit s = v && (in_frame ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 3) == 0));
      drive(v, s, rnd(), rnd());
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
